serial_frame_receiver: RTL and testbench

SERIAL_FRAME_RECEIVER -- requirements
Module: serial_frame_receiver

---
 rtl/serial_frame_receiver.sv | 167 ++++++++++++++++
 tb/tb_serial_frame_receiver.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/serial_frame_receiver.sv
// Frames a byte stream from an async receiver into an NBYTES payload with optional header and checksum.
// Commit latency is 1 cycle from the final strobe; stalled frames are aborted after TIMEOUT_CYCLES idle cycles.
module serial_frame_receiver #(
  parameter int unsigned NBYTES         = 44,
  parameter int unsigned TIMEOUT_CYCLES = 8388608,
  parameter bit          SYNC_EN        = 1'b1,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter bit          CSUM_EN        = 1'b1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          rx_data,
  input  logic                rx_ready,
  output logic [NBYTES*8-1:0] data,
  output logic                load_flag,
  output logic                frame_done,
  output logic                frame_err,
  output logic [7:0]          err_count,
  output logic                busy
);
  localparam int unsigned DW    = NBYTES * 8;
  localparam int unsigned CNT_W = $clog2(NBYTES + 1);
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {ST_HUNT, ST_PAYLOAD, ST_CSUM} state_t;
  localparam state_t START_ST = SYNC_EN ? ST_HUNT : ST_PAYLOAD;

  state_t             state_q, state_d;
  logic [DW-1:0]      buf_q, buf_d, buf_shift;
  logic [7:0]         sum_q, sum_d, sum_add;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic [DW-1:0]      data_q, data_d;
  logic               load_flag_q, load_flag_d;
  logic               frame_done_q, frame_done_d;
  logic               frame_err_q, frame_err_d;
  logic [7:0]         err_count_q, err_count_d;
  logic               last_byte, tmo_hit, commit, fail;

  generate
    if (NBYTES == 1) begin : g_shift_one
      assign buf_shift = rx_data;
    end else begin : g_shift_many
      assign buf_shift = {buf_q[DW-9:0], rx_data};
    end
  endgenerate

  assign sum_add   = sum_q + rx_data;
  assign last_byte = (cnt_q == CNT_W'(NBYTES - 1));
  // A strobe on the would-be timeout cycle wins over the abort.
  assign tmo_hit   = !rx_ready && (state_q != START_ST) &&
                     (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) state_q <= START_ST;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = START_ST;
    end else if (rx_ready) begin
      case (state_q)
        ST_HUNT:    if (rx_data == SYNC_BYTE) state_d = ST_PAYLOAD;
        ST_PAYLOAD: if (last_byte) state_d = CSUM_EN ? ST_CSUM : START_ST;
        ST_CSUM:    state_d = START_ST;
        default:    state_d = START_ST;
      endcase
    end
  end

  always_comb begin
    buf_d        = buf_q;
    sum_d        = sum_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    load_flag_d  = load_flag_q;
    frame_done_d = 1'b0;
    frame_err_d  = 1'b0;
    err_count_d  = err_count_q;
    commit       = 1'b0;
    fail         = 1'b0;
    tmo_d        = tmo_q;

    if (rx_ready || state_q == START_ST) tmo_d = '0;
    else if (tmo_q != TMO_W'(TIMEOUT_CYCLES)) tmo_d = tmo_q + 1'b1;

    if (tmo_hit) begin
      fail  = 1'b1;
      tmo_d = '0;
    end else if (rx_ready) begin
      case (state_q)
        ST_HUNT: begin
          if (rx_data == SYNC_BYTE) begin
            cnt_d = '0;
            sum_d = '0;
          end
        end
        ST_PAYLOAD: begin
          buf_d = buf_shift;
          sum_d = sum_add;
          cnt_d = cnt_q + 1'b1;
          if (last_byte && !CSUM_EN) begin
            commit = 1'b1;
            data_d = buf_shift;
          end
        end
        ST_CSUM: begin
          if (sum_add == 8'h00) begin
            commit = 1'b1;
            data_d = buf_q;
          end else begin
            fail = 1'b1;
          end
        end
        default: ;
      endcase
    end

    if (commit) begin
      load_flag_d  = ~load_flag_q;
      frame_done_d = 1'b1;
    end
    if (fail) begin
      frame_err_d = 1'b1;
      if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
    end
    // Returning to the start state always begins a fresh frame.
    if (commit || fail) begin
      cnt_d = '0;
      sum_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      buf_q        <= '0;
      sum_q        <= '0;
      cnt_q        <= '0;
      tmo_q        <= '0;
      data_q       <= '0;
      load_flag_q  <= 1'b0;
      frame_done_q <= 1'b0;
      frame_err_q  <= 1'b0;
      err_count_q  <= '0;
    end else begin
      buf_q        <= buf_d;
      sum_q        <= sum_d;
      cnt_q        <= cnt_d;
      tmo_q        <= tmo_d;
      data_q       <= data_d;
      load_flag_q  <= load_flag_d;
      frame_done_q <= frame_done_d;
      frame_err_q  <= frame_err_d;
      err_count_q  <= err_count_d;
    end
  end

  assign data       = data_q;
  assign load_flag  = load_flag_q;
  assign frame_done = frame_done_q;
  assign frame_err  = frame_err_q;
  assign err_count  = err_count_q;
  assign busy       = (state_q != START_ST);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Scoreboard bench: a header/checksum receiver (a) and a raw fixed-length receiver (b), both NBYTES=4.
module tb_serial_frame_receiver;
  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rxd_a, rxd_b;
  logic        rxr_a, rxr_b;
  logic [31:0] data_a, data_b;
  logic        lf_a, lf_b, fd_a, fd_b, fe_a, fe_b, busy_a, busy_b;
  logic [7:0]  ec_a, ec_b;
  int          cyc = 0;
  int          n_chk = 0;
  int          n_pass = 0;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    bit          lf;
    logic [7:0]  ec;
    int          cyc;
  } exp_t;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;

  logic [31:0] m_data_a, m_data_b;
  bit          m_lf_a, m_lf_b;
  logic [7:0]  m_ec_a;

  serial_frame_receiver #(.NBYTES(4), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .reset(reset), .rx_data(rxd_a), .rx_ready(rxr_a),
    .data(data_a), .load_flag(lf_a), .frame_done(fd_a), .frame_err(fe_a),
    .err_count(ec_a), .busy(busy_a)
  );

  serial_frame_receiver #(.NBYTES(4), .TIMEOUT_CYCLES(100), .SYNC_EN(1'b0), .CSUM_EN(1'b0)) dut_b (
    .clk(clk), .reset(reset), .rx_data(rxd_b), .rx_ready(rxr_b),
    .data(data_b), .load_flag(lf_b), .frame_done(fd_b), .frame_err(fe_b),
    .err_count(ec_b), .busy(busy_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    else n_pass++;
  endtask

  always @(negedge clk) begin
    if (fd_a || fe_a) begin
      chk("a_excl", fd_a && fe_a, 0);
      if (q_a.size() == 0) begin
        chk("a_unexpected_pulse", 1, 0);
      end else begin
        e_a = q_a.pop_front();
        chk("a_kind_err", fe_a, e_a.is_err);
        chk("a_cycle", cyc, e_a.cyc);
        chk("a_data", data_a, e_a.data);
        chk("a_load_flag", lf_a, e_a.lf);
        chk("a_err_count", ec_a, e_a.ec);
        chk("a_busy_after", busy_a, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (fd_b || fe_b) begin
      if (q_b.size() == 0) begin
        chk("b_unexpected_pulse", 1, 0);
      end else begin
        e_b = q_b.pop_front();
        chk("b_kind_err", fe_b, e_b.is_err);
        chk("b_cycle", cyc, e_b.cyc);
        chk("b_data", data_b, e_b.data);
        chk("b_load_flag", lf_b, e_b.lf);
        chk("b_busy_after", busy_b, 0);
      end
    end
  end

  // Expectations are pushed right before the final byte is driven from a negedge.
  task automatic exp_done_a(input logic [31:0] d);
    m_lf_a   = ~m_lf_a;
    m_data_a = d;
    q_a.push_back('{is_err: 1'b0, data: d, lf: m_lf_a, ec: m_ec_a, cyc: cyc + 1});
  endtask

  task automatic exp_err_a(input int lat);
    if (m_ec_a != 8'hFF) m_ec_a = m_ec_a + 8'd1;
    q_a.push_back('{is_err: 1'b1, data: m_data_a, lf: m_lf_a, ec: m_ec_a, cyc: cyc + lat});
  endtask

  task automatic send_a(input logic [7:0] b);
    rxd_a = b;
    rxr_a = 1'b1;
    @(negedge clk);
    rxr_a = 1'b0;
  endtask

  task automatic send_b(input logic [7:0] b);
    rxd_b = b;
    rxr_b = 1'b1;
    @(negedge clk);
    rxr_b = 1'b0;
  endtask

  task automatic frame_a(input logic [31:0] d, input logic [7:0] cs);
    logic [7:0] s;
    logic [7:0] t;
    s = d[31:24] + d[23:16] + d[15:8] + d[7:0];
    t = s + cs;
    send_a(8'hA5);
    for (int i = 3; i >= 0; i--) send_a(d[i*8 +: 8]);
    if (t == 8'h00) exp_done_a(d);
    else exp_err_a(1);
    send_a(cs);
  endtask

  task automatic frame_b(input logic [31:0] d);
    for (int i = 3; i >= 1; i--) send_b(d[i*8 +: 8]);
    m_lf_b   = ~m_lf_b;
    m_data_b = d;
    q_b.push_back('{is_err: 1'b0, data: d, lf: m_lf_b, ec: 8'h00, cyc: cyc + 1});
    send_b(d[7:0]);
  endtask

  task automatic model_reset();
    m_data_a = '0; m_lf_a = 1'b0; m_ec_a = '0;
    m_data_b = '0; m_lf_b = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic [7:0]  cs;
    reset = 1'b1;
    rxd_a = '0; rxr_a = 1'b0;
    rxd_b = '0; rxr_b = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_data", data_a, 0);
    chk("rst_load_flag", lf_a, 0);
    chk("rst_frame_done", fd_a, 0);
    chk("rst_frame_err", fe_a, 0);
    chk("rst_err_count", ec_a, 0);
    chk("rst_busy_a", busy_a, 0);
    chk("rst_busy_b", busy_b, 0);
    reset = 1'b0;
    @(negedge clk);

    frame_a(32'h01020304, 8'hF6);
    repeat (3) @(negedge clk);
    frame_a(32'h01020304, 8'h00);
    repeat (3) @(negedge clk);

    send_a(8'hA5);
    chk("busy_in_frame", busy_a, 1);
    exp_err_a(101);
    send_a(8'h01);
    repeat (110) @(negedge clk);
    frame_a(32'h01020304, 8'hF6);
    repeat (3) @(negedge clk);

    send_a(8'hA5);
    send_a(8'h10);
    repeat (99) @(negedge clk);
    send_a(8'h20);
    send_a(8'h30);
    send_a(8'h40);
    exp_done_a(32'h10203040);
    send_a(8'h60);
    repeat (3) @(negedge clk);

    send_a(8'h00);
    send_a(8'hFF);
    frame_a(32'h0A0B0C0D, 8'hD2);
    repeat (3) @(negedge clk);

    send_a(8'hA5);
    send_a(8'h01);
    send_a(8'h02);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    chk("midrst_busy", busy_a, 0);
    chk("midrst_err_count", ec_a, 0);
    chk("midrst_load_flag", lf_a, 0);
    frame_a(32'hDEADBEEF, 8'h00 - (8'hDE + 8'hAD + 8'hBE + 8'hEF));
    frame_a(32'h01020304, 8'hF6);
    @(negedge clk);
    chk("b2b_load_flag", lf_a, 0);

    for (int i = 0; i < 20; i++) begin
      d  = $urandom;
      cs = 8'h00 - (d[31:24] + d[23:16] + d[15:8] + d[7:0]);
      if (i % 3 == 0) cs = cs + 8'($urandom_range(1, 255));
      frame_a(d, cs);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    for (int i = 0; i < 258; i++) frame_a(32'h01020304, 8'h55);
    @(negedge clk);
    chk("sat_err_count", ec_a, 8'hFF);

    frame_b(32'h11223344);
    frame_b(32'h55667788);

    repeat (20) @(negedge clk);
    chk("a_pending", q_a.size(), 0);
    chk("b_pending", q_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
